// File: rtl/slam_stage_sched_pkg.sv
// Shared stage codes, FSM states and command record for the EKF-SLAM stage scheduler.
// The core imports the same package so both sides agree on the stage encoding.
package slam_stage_sched_pkg;

    localparam int unsigned OP_W = 32;

    typedef enum logic [2:0] {
        STAGE_IDLE  = 3'b000,
        STAGE_PRD   = 3'b001,
        STAGE_NEW   = 3'b010,
        STAGE_UPD   = 3'b011,
        STAGE_ASSOC = 3'b100
    } stage_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP
    } state_e;

    typedef struct packed {
        logic [2:0]      stage;
        logic [OP_W-1:0] op0;
        logic [OP_W-1:0] op1;
    } cmd_t;

    function automatic logic stage_is_legal(input logic [2:0] code);
        return (code >= 3'(STAGE_PRD)) && (code <= 3'(STAGE_ASSOC));
    endfunction

endpackage

// File: rtl/slam_stage_sched_fifo.sv
// Command FIFO: DEPTH entries, count-based full/empty, show-ahead head word.
// Ready is registered from the next count so it is exactly !full every cycle.
module slam_cmd_fifo
    import slam_stage_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic i_push,
    input  cmd_t i_wdata,
    input  logic i_pop,
    output cmd_t o_head,
    output logic o_empty,
    output logic o_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count != FULL_CNT);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_ready = r_ready;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/slam_stage_sched.sv
// Stage command scheduler for the EKF-SLAM core: queues PS commands, issues them one at a
// time with a forced IDLE->code edge, routes operands and watchdogs each stage.
module slam_stage_sched
    import slam_stage_sched_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned CNT_DW      = 16
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_stage,
    input  logic [31:0]       cmd_op0,
    input  logic [31:0]       cmd_op1,
    output logic [2:0]        stage_val,
    input  logic              stage_rdy,
    output logic [31:0]       vlr,
    output logic [31:0]       alpha,
    output logic [31:0]       rk,
    output logic [31:0]       phi,
    output logic              busy,
    output logic              done,
    output logic [2:0]        done_stage,
    output logic              err_timeout,
    output logic              err_illegal,
    output logic [CNT_DW-1:0] stage_cnt
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e            r_state;
    state_e            w_state_next;
    cmd_t              r_cur;
    cmd_t              w_head;
    cmd_t              w_wdata;
    logic              w_empty;
    logic              w_fifo_ready;
    logic              w_accept;
    logic              w_fifo_push;
    logic              w_pop;
    logic              w_complete;
    logic              w_abort;
    logic              r_arm;
    logic [GW-1:0]     r_gap;
    logic [WW-1:0]     r_wd;
    logic [31:0]       r_vlr;
    logic [31:0]       r_alpha;
    logic [31:0]       r_rk;
    logic [31:0]       r_phi;
    logic              r_done;
    logic [2:0]        r_done_stage;
    logic              r_err_timeout;
    logic              r_err_illegal;
    logic [CNT_DW-1:0] r_stage_cnt;

    assign w_accept    = cmd_valid && w_fifo_ready;
    assign w_fifo_push = w_accept && stage_is_legal(cmd_stage);
    assign w_wdata     = '{stage: cmd_stage, op0: cmd_op0, op1: cmd_op1};

    slam_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .sys_rst (sys_rst),
        .i_push  (w_fifo_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_ready (w_fifo_ready)
    );

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Normal completion takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (stage_rdy && r_arm) begin
                    w_complete   = 1'b1;
                    w_state_next = S_GAP;
                end else if ((TIMEOUT_CYC != 0) && (r_wd == WD_LAST)) begin
                    w_abort      = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_cur         <= '0;
            r_arm         <= 1'b0;
            r_gap         <= '0;
            r_wd          <= '0;
            r_vlr         <= '0;
            r_alpha       <= '0;
            r_rk          <= '0;
            r_phi         <= '0;
            r_done        <= 1'b0;
            r_done_stage  <= '0;
            r_err_timeout <= 1'b0;
            r_err_illegal <= 1'b0;
            r_stage_cnt   <= '0;
        end else begin
            r_done <= w_complete || w_abort;
            if (w_pop) begin
                r_cur <= w_head;
            end
            if (r_state == S_LOAD) begin
                if (r_cur.stage == 3'(STAGE_PRD)) begin
                    r_vlr   <= r_cur.op0;
                    r_alpha <= r_cur.op1;
                end else begin
                    r_rk  <= r_cur.op0;
                    r_phi <= r_cur.op1;
                end
                r_arm <= 1'b0;
                r_wd  <= '0;
            end else if (r_state == S_RUN) begin
                r_wd <= r_wd + 1'b1;
                if (!stage_rdy) begin
                    r_arm <= 1'b1;
                end
            end
            if (r_state == S_GAP) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end
            if (w_complete || w_abort) begin
                r_done_stage <= r_cur.stage;
            end
            if (w_complete) begin
                r_stage_cnt <= r_stage_cnt + 1'b1;
            end
            if (w_abort) begin
                r_err_timeout <= 1'b1;
            end
            if (w_accept && !stage_is_legal(cmd_stage)) begin
                r_err_illegal <= 1'b1;
            end
        end
    end

    assign cmd_ready   = w_fifo_ready;
    assign stage_val   = (r_state == S_RUN) ? r_cur.stage : '0;
    assign vlr         = r_vlr;
    assign alpha       = r_alpha;
    assign rk          = r_rk;
    assign phi         = r_phi;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign done        = r_done;
    assign done_stage  = r_done_stage;
    assign err_timeout = r_err_timeout;
    assign err_illegal = r_err_illegal;
    assign stage_cnt   = r_stage_cnt;

endmodule

// File: tb/tb_slam_stage_sched.sv
// Self-checking bench for slam_stage_sched: directed table, stall/timeout/reset sequences and
// randomized commands checked against a queue-based model of issue order, operands and status.
module tb_slam_stage_sched;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned GAP_CYC     = 2;
    localparam int unsigned TIMEOUT_CYC = 20;
    localparam int unsigned CNT_DW      = 16;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_stage;
    logic [31:0]       cmd_op0;
    logic [31:0]       cmd_op1;
    logic [2:0]        stage_val;
    logic              stage_rdy;
    logic [31:0]       vlr;
    logic [31:0]       alpha;
    logic [31:0]       rk;
    logic [31:0]       phi;
    logic              busy;
    logic              done;
    logic [2:0]        done_stage;
    logic              err_timeout;
    logic              err_illegal;
    logic [CNT_DW-1:0] stage_cnt;

    always #5 clk = ~clk;

    slam_stage_sched #(
        .DEPTH       (DEPTH),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_DW      (CNT_DW)
    ) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_stage   (cmd_stage),
        .cmd_op0     (cmd_op0),
        .cmd_op1     (cmd_op1),
        .stage_val   (stage_val),
        .stage_rdy   (stage_rdy),
        .vlr         (vlr),
        .alpha       (alpha),
        .rk          (rk),
        .phi         (phi),
        .busy        (busy),
        .done        (done),
        .done_stage  (done_stage),
        .err_timeout (err_timeout),
        .err_illegal (err_illegal),
        .stage_cnt   (stage_cnt)
    );

    typedef struct {
        logic [2:0]  stage;
        logic [31:0] op0;
        logic [31:0] op1;
        bit          hang;
        int unsigned drop;
        int unsigned hold;
    } cmd_s;

    typedef struct {
        logic [2:0]  stage;
        logic [31:0] op0;
        logic [31:0] op1;
        bit          hang;
        int unsigned drop;
        int unsigned hold;
        bit          sync;
        int unsigned exp_cnt;
        bit          exp_to;
        bit          exp_ill;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    cmd_s        exp_q[$];
    cmd_s        beh_q[$];
    logic [31:0] m_vlr, m_alpha, m_rk, m_phi;
    int unsigned m_cnt;
    bit          m_to, m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        exp_q.delete();
        beh_q.delete();
        m_vlr = '0; m_alpha = '0; m_rk = '0; m_phi = '0;
        m_cnt = 0; m_to = 1'b0; m_ill = 1'b0;
    endtask

    task automatic push(input logic [2:0] st, input logic [31:0] a, input logic [31:0] b,
                        input bit hang, input int unsigned drop, input int unsigned hold);
        cmd_s        c;
        int unsigned t;
        t = 0;
        cmd_valid = 1'b1; cmd_stage = st; cmd_op0 = a; cmd_op1 = b;
        while (!cmd_ready && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (!cmd_ready) begin
            chk("push_wait_ready", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        c.stage = st; c.op0 = a; c.op1 = b; c.hang = hang; c.drop = drop; c.hold = hold;
        if (st >= 3'd1 && st <= 3'd4) begin
            exp_q.push_back(c);
            beh_q.push_back(c);
        end else begin
            m_ill = 1'b1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while (busy && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stage_val"}, stage_val, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_stage"}, done_stage, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
        chk({tag, "_err_illegal"}, err_illegal, 0);
        chk({tag, "_stage_cnt"}, stage_cnt, 0);
        chk({tag, "_ops"}, {vlr, alpha} | {rk, phi}, 0);
    endtask

    // Core model: drops stage_rdy 'drop' cycles after the issue edge, raises it 'hold' later.
    initial begin
        cmd_s        b;
        int unsigned t;
        stage_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (!sys_rst && stage_val != 3'd0 && beh_q.size() != 0) begin
                b = beh_q.pop_front();
                repeat (b.drop) @(posedge clk);
                #1 stage_rdy = 1'b0;
                if (!b.hang) begin
                    repeat (b.hold) @(posedge clk);
                    #1 stage_rdy = 1'b1;
                end
                t = 0;
                while (stage_val != 3'd0 && t < 200) begin
                    @(posedge clk); #1; t++;
                end
                stage_rdy = 1'b1;
            end
        end
    end

    // Monitor: issue order, IDLE spacing, operand routing/stability, done and status.
    initial begin
        logic [2:0]  prev_sv;
        int unsigned idle_cnt;
        int unsigned run_len;
        bit          active;
        bit          prev_done;
        cmd_s        cur;
        prev_sv = '0; idle_cnt = 100; run_len = 0; active = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                prev_sv = '0; idle_cnt = 100; active = 1'b0; prev_done = 1'b0;
                continue;
            end
            if (prev_sv == 3'd0 && stage_val != 3'd0) begin
                chk("issue_idle_gap", idle_cnt >= GAP_CYC + 2, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", stage_val, 0);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    run_len = 0;
                    chk("issue_stage", stage_val, cur.stage);
                    if (cur.stage == 3'd1) begin
                        m_vlr = cur.op0; m_alpha = cur.op1;
                    end else begin
                        m_rk = cur.op0; m_phi = cur.op1;
                    end
                    chk("issue_vlr", vlr, m_vlr);
                    chk("issue_alpha", alpha, m_alpha);
                    chk("issue_rk", rk, m_rk);
                    chk("issue_phi", phi, m_phi);
                end
            end else if (stage_val != 3'd0) begin
                chk("run_stage_stable", stage_val, prev_sv);
                chk("run_ops_stable", {vlr, alpha, rk, phi} == {m_vlr, m_alpha, m_rk, m_phi}, 1);
            end
            if (stage_val != 3'd0) run_len++;
            if (prev_done) chk("done_pulse", done, 0);
            if (done) begin
                if (!active) begin
                    chk("done_without_stage", done, 0);
                end else begin
                    active = 1'b0;
                    chk("done_stage", done_stage, cur.stage);
                    chk("done_in_gap", stage_val, 0);
                    if (cur.hang) begin
                        m_to = 1'b1;
                        chk("timeout_run_len", run_len, TIMEOUT_CYC);
                    end else begin
                        m_cnt++;
                    end
                    chk("done_stage_cnt", stage_cnt, m_cnt[15:0]);
                    chk("done_err_timeout", err_timeout, m_to);
                end
            end
            prev_done = done;
            idle_cnt  = (stage_val == 3'd0) ? idle_cnt + 1 : 0;
            prev_sv   = stage_val;
        end
    end

    initial begin
        vec_t        tbl[8];
        int unsigned t;
        logic [2:0]  st;
        logic [2:0]  bad_codes[4];

        tbl[0] = '{3'd1, 32'h0001_0000, 32'h0000_8000, 0, 3, 10, 1, 1, 0, 0};
        tbl[1] = '{3'd3, 32'h1111_1111, 32'hF222_2222, 0, 2, 4,  0, 0, 0, 0};
        tbl[2] = '{3'd2, 32'h3333_3333, 32'h4444_4444, 0, 1, 5,  0, 0, 0, 0};
        tbl[3] = '{3'd4, 32'h5555_5555, 32'h6666_6666, 0, 4, 2,  1, 4, 0, 0};
        tbl[4] = '{3'd4, 32'h7777_7777, 32'h8888_8888, 1, 2, 0,  1, 4, 1, 0};
        tbl[5] = '{3'd1, 32'hAAAA_0001, 32'hBBBB_0002, 0, 1, 3,  1, 5, 1, 0};
        tbl[6] = '{3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 1, 1,  0, 0, 0, 0};
        tbl[7] = '{3'd1, 32'h0000_0042, 32'hFFFF_FFFE, 0, 2, 2,  1, 6, 1, 1};
        bad_codes[0] = 3'd0; bad_codes[1] = 3'd5; bad_codes[2] = 3'd6; bad_codes[3] = 3'd7;

        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_stage = '0; cmd_op0 = '0; cmd_op1 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        sys_rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", cmd_ready, 1);

        // Directed table: PRD, back-to-back UPD/NEW/ASSOC, timeout, recovery, illegal code.
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].stage, tbl[i].op0, tbl[i].op1, tbl[i].hang, tbl[i].drop, tbl[i].hold);
            if (tbl[i].sync) begin
                wait_idle();
                chk("tbl_stage_cnt", stage_cnt, tbl[i].exp_cnt);
                chk("tbl_err_timeout", err_timeout, tbl[i].exp_to);
                chk("tbl_err_illegal", err_illegal, tbl[i].exp_ill);
            end
        end

        // Stall: one long stage running, four more fill the FIFO, a fifth is held off.
        push(3'd2, 32'h0BAD_0001, 32'h0BAD_0002, 0, 1, 15);
        t = 0;
        while (stage_val == 3'd0 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("stall_running", stage_val, 3'd2);
        for (int i = 0; i < 4; i++) begin
            push(3'(1 + (i % 4)), 32'h1000_0000 + i, 32'h2000_0000 + i, 0, 1, 2);
            if (i == 2) chk("stall_ready_3", cmd_ready, 1);
        end
        chk("stall_ready_full", cmd_ready, 0);
        chk("stall_busy", busy, 1);
        push(3'd3, 32'h3000_0005, 32'h4000_0005, 0, 2, 1);
        wait_idle();
        chk("stall_stage_cnt", stage_cnt, 12);

        // Randomized commands with occasional illegal codes and hung stages.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) st = bad_codes[$urandom_range(0, 3)];
            else st = 3'($urandom_range(1, 4));
            push(st, $urandom, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(1, 4), $urandom_range(1, 8));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        chk("rand_stage_cnt", stage_cnt, m_cnt[15:0]);
        chk("rand_err_timeout", err_timeout, m_to);
        chk("rand_err_illegal", err_illegal, m_ill);
        chk("rand_queue_drained", exp_q.size(), 0);

        // Reset in the middle of a running stage with two commands queued.
        push(3'd1, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 0, 1, 15);
        push(3'd3, 32'h0000_1111, 32'h0000_2222, 0, 1, 1);
        push(3'd4, 32'h0000_3333, 32'h0000_4444, 0, 1, 1);
        t = 0;
        while (stage_val == 3'd0 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("midrst_running", stage_val, 3'd1);
        sys_rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrst");
        model_clear();
        sys_rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_no_issue", stage_val, 0);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_ready", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
